// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path: channel word width,
// serializer bit-counter preload, left/right pair record and serializer states.
package audio_pkg;

    localparam int         AUDIO_DATA_WIDTH = 32;
    localparam logic [4:0] BIT_COUNTER_INIT = 5'd31;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } audio_pair_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_DELAY,
        SER_SHIFT
    } ser_state_t;

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of left/right sample pairs; power-of-two depth, pointers
// carry one extra wrap bit so level, full and empty come straight from them.
module audio_pair_fifo
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  audio_pair_t                 push_data,
    input  logic                        pop,
    output audio_pair_t                 pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    audio_pair_t mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Buffers parallel L/R pairs and shifts them MSB-first onto the codec DAC line
// in I2S format, timed by the synchronised codec BCLK/LRCK.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_in,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow
);

    localparam int CNT_W = $bits(BIT_COUNTER_INIT);

    logic bclk_p0, bclk_p1, bclk_p2;
    logic lrck_p0, lrck_p1, lrck_p2;
    logic bclk_fall, lrck_fall, lrck_rise;

    audio_pair_t in_pair;
    audio_pair_t head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    ser_state_t                  state, state_n;
    logic [CNT_W-1:0]            count, count_n;
    logic [AUDIO_DATA_WIDTH-1:0] shift, shift_n;
    logic [AUDIO_DATA_WIDTH-1:0] hold_r, hold_r_n;
    logic                        started, started_n;
    logic                        dat_n;
    logic                        underflow_n;

    // Stage p0/p1 resolve metastability, p2 is the edge-detect history
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            {bclk_p0, bclk_p1, bclk_p2} <= '0;
            {lrck_p0, lrck_p1, lrck_p2} <= '0;
        end else begin
            {bclk_p0, bclk_p1, bclk_p2} <= {AUD_BCLK, bclk_p0, bclk_p1};
            {lrck_p0, lrck_p1, lrck_p2} <= {AUD_DACLRCK, lrck_p0, lrck_p1};
        end
    end

    assign bclk_fall = bclk_p2 & ~bclk_p1;
    assign lrck_fall = lrck_p2 & ~lrck_p1;
    assign lrck_rise = ~lrck_p2 & lrck_p1;

    assign in_pair  = {left_in, right_in};
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = lrck_fall & ~empty;

    audio_pair_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst      (reset),
        .push     (push),
        .push_data(in_pair),
        .pop      (pop),
        .pop_data (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= SER_IDLE;
            count      <= '0;
            shift      <= '0;
            hold_r     <= '0;
            started    <= 1'b0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            shift      <= shift_n;
            hold_r     <= hold_r_n;
            started    <= started_n;
            AUD_DACDAT <= dat_n;
            underflow  <= underflow_n;
        end
    end

    // A BCLK fall coinciding with the LR edge is the I2S delay slot itself,
    // so the word goes straight to SHIFT; otherwise the next fall is skipped.
    always_comb begin
        state_n     = state;
        count_n     = count;
        shift_n     = shift;
        hold_r_n    = hold_r;
        started_n   = started;
        dat_n       = AUD_DACDAT;
        underflow_n = 1'b0;
        if (lrck_fall) begin
            started_n = 1'b1;
            count_n   = BIT_COUNTER_INIT;
            state_n   = bclk_fall ? SER_SHIFT : SER_DELAY;
            if (empty) begin
                shift_n     = '0;
                hold_r_n    = '0;
                underflow_n = 1'b1;
            end else begin
                shift_n  = head.left;
                hold_r_n = head.right;
            end
        end else if (lrck_rise && started) begin
            shift_n = hold_r;
            count_n = BIT_COUNTER_INIT;
            state_n = bclk_fall ? SER_SHIFT : SER_DELAY;
        end else if (bclk_fall) begin
            case (state)
                SER_DELAY: state_n = SER_SHIFT;
                SER_SHIFT: begin
                    dat_n   = shift[AUDIO_DATA_WIDTH-1];
                    shift_n = {shift[AUDIO_DATA_WIDTH-2:0], 1'b0};
                    if (count == '0) state_n = SER_IDLE;
                    else             count_n = count - 1'b1;
                end
                default: dat_n = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: drives codec BCLK/LRCK, predicts
// each DAC slot from the I2S framing rules and a queue model of the pair FIFO.
module tb_audio_dac_serializer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        in_valid;
    logic        in_ready;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [2:0]  fifo_level;
    logic        underflow;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_dac_serializer #(.FIFO_DEPTH(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .left_in    (left_in),
        .right_in   (right_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .AUD_BCLK   (AUD_BCLK),
        .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT (AUD_DACDAT),
        .fifo_level (fifo_level),
        .underflow  (underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic [63:0] offer_q[$];
    logic [31:0] m_word;
    logic [31:0] m_hold_r;
    logic        m_started;
    logic        m_loaded;
    logic        m_prev;
    int          m_slot;
    int          m_uf_exp = 0;
    int          uf_seen  = 0;
    logic [31:0] cap = '0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [30:0] exp_l;
        logic [30:0] exp_r;
    } vec_t;
    vec_t tbl[4];

    always @(posedge CLOCK_50) if (underflow === 1'b1) uf_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_word = '0; m_hold_r = '0;
        m_started = 1'b0; m_loaded = 1'b0; m_prev = 1'b0; m_slot = 0;
    endtask

    task automatic model_edge(input logic lr);
        logic [63:0] p;
        if (lr == 1'b0) begin
            m_started = 1'b1;
            if (m_q.size() > 0) begin
                p = m_q.pop_front();
                m_word = p[63:32]; m_hold_r = p[31:0];
            end else begin
                m_word = '0; m_hold_r = '0; m_uf_exp++;
            end
            m_loaded = 1'b1; m_slot = 0;
        end else if (m_started) begin
            m_word = m_hold_r; m_loaded = 1'b1; m_slot = 0;
        end
    endtask

    // Slot 0 after an LR edge repeats the previous bit, slots 1..32 carry the
    // word MSB first, later slots are zero.
    task automatic model_fall(output logic e);
        if (!m_loaded)        e = 1'b0;
        else if (m_slot == 0) e = m_prev;
        else if (m_slot <= 32) e = m_word[32-m_slot];
        else                  e = 1'b0;
        m_slot++;
        m_prev = e;
    endtask

    task automatic try_offer();
        if (offer_q.size() > 0 && in_ready) begin
            {left_in, right_in} = offer_q[0];
            in_valid = 1'b1;
            m_q.push_back(offer_q.pop_front());
        end
    endtask

    task automatic push_pair(input logic [63:0] p);
        @(negedge CLOCK_50);
        check("push_ready", in_ready, 1'b1);
        if (in_ready) begin
            {left_in, right_in} = p;
            in_valid = 1'b1;
            m_q.push_back(p);
        end
        @(negedge CLOCK_50);
        in_valid = 1'b0;
    endtask

    task automatic drive_half(input logic lr, input int nb, input int stop_after,
                              input bit edge_push, input logic [63:0] edge_pair);
        logic e;
        for (int j = 0; j < nb; j++) begin
            if (j == stop_after) return;
            @(negedge CLOCK_50);
            AUD_BCLK = 1'b0;
            if (j == 0 && lr !== AUD_DACLRCK) begin
                model_edge(lr);
                AUD_DACLRCK = lr;
            end
            model_fall(e);
            for (int c = 1; c < 8; c++) begin
                @(negedge CLOCK_50);
                if (j == 0 && edge_push && c == 2) begin
                    check("edge_push_ready", in_ready, 1'b1);
                    {left_in, right_in} = edge_pair;
                    in_valid = 1'b1;
                    m_q.push_back(edge_pair);
                end
                if (j == 0 && edge_push && c == 3) in_valid = 1'b0;
                if (j == 4 && c == 1) try_offer();
                if (j == 4 && c == 2) in_valid = 1'b0;
                if (j == 0 && c == 7) begin
                    check("fifo_level", fifo_level, m_q.size());
                    check("in_ready", in_ready, m_q.size() < 4);
                end
            end
            @(negedge CLOCK_50);
            check("dacdat", AUD_DACDAT, e);
            cap = {cap[30:0], AUD_DACDAT};
            AUD_BCLK = 1'b1;
            repeat (7) @(negedge CLOCK_50);
        end
    endtask

    initial begin
        logic [63:0] p;
        logic        lr;
        int          acc;
        int          lens[5] = '{24, 32, 33, 34, 40};

        tbl[0] = '{32'h80000001, 32'h7FFFFFFE, 31'h40000000, 31'h3FFFFFFF};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 31'h7FFFFFFF, 31'h00000000};
        tbl[2] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 31'h52D2D2D2, 31'h2D2D2D2D};
        tbl[3] = '{32'h12345678, 32'h89ABCDEF, 31'h091A2B3C, 31'h44D5E6F7};

        reset = 1'b1; in_valid = 1'b0; left_in = '0; right_in = '0;
        AUD_BCLK = 1'b1; AUD_DACLRCK = 1'b0;
        model_reset();
        repeat (4) @(negedge CLOCK_50);
        check("rst_dacdat", AUD_DACDAT, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        check("rst_underflow", underflow, 1'b0);
        reset = 1'b0;

        // Idle link: first rise ignored, then one underflow per left slot
        drive_half(1'b1, 32, -1, 1'b0, '0);
        drive_half(1'b0, 32, -1, 1'b0, '0);
        drive_half(1'b1, 32, -1, 1'b0, '0);
        drive_half(1'b0, 32, -1, 1'b0, '0);
        drive_half(1'b1, 32, -1, 1'b0, '0);
        check("idle_uf_count", uf_seen, m_uf_exp);
        check("idle_uf_two", m_uf_exp, 2);

        // Directed pairs, 64 BCLK per frame
        for (int i = 0; i < 4; i++) begin
            push_pair({tbl[i].l, tbl[i].r});
            drive_half(1'b0, 32, -1, 1'b0, '0);
            check("tbl_left", cap[30:0], tbl[i].exp_l);
            drive_half(1'b1, 32, -1, 1'b0, '0);
            check("tbl_right", cap[30:0], tbl[i].exp_r);
        end
        check("tbl_uf_count", uf_seen, m_uf_exp);

        // Fill to full with LRCK stopped, then let the link drain it
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK_50);
            p = {$urandom, $urandom};
            {left_in, right_in} = p;
            in_valid = 1'b1;
            if (in_ready) begin
                acc++;
                m_q.push_back(p);
            end
        end
        @(negedge CLOCK_50);
        in_valid = 1'b0;
        check("full_accepted", acc, 4);
        check("full_in_ready", in_ready, 1'b0);
        check("full_level", fifo_level, 3'd4);
        for (int h = 0; h < 8; h++) drive_half(h[0] ? 1'b1 : 1'b0, 32, -1, 1'b0, '0);

        // Push coinciding with pop at level 2
        push_pair({$urandom, $urandom});
        push_pair({$urandom, $urandom});
        check("pre_coincide_level", fifo_level, 3'd2);
        drive_half(1'b0, 32, -1, 1'b1, {$urandom, $urandom});
        for (int h = 1; h < 8; h++) drive_half(h[0] ? 1'b1 : 1'b0, 32, -1, 1'b0, '0);
        check("coincide_uf_count", uf_seen, m_uf_exp);

        // Reset after 10 bits of a left word
        push_pair({$urandom, $urandom});
        drive_half(1'b0, 32, 11, 1'b0, '0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check("midrst_dacdat", AUD_DACDAT, 1'b0);
        check("midrst_level", fifo_level, 3'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_underflow", underflow, 1'b0);
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        offer_q.push_back({$urandom, $urandom});
        drive_half(1'b0, 21, -1, 1'b0, '0);
        drive_half(1'b1, 32, -1, 1'b0, '0);
        drive_half(1'b0, 32, -1, 1'b0, '0);
        drive_half(1'b1, 32, -1, 1'b0, '0);
        check("midrst_uf_count", uf_seen, m_uf_exp);

        // Short frames: 24 BCLK per half keeps the 23 MSBs
        for (int k = 0; k < 2; k++) begin
            p = {$urandom, $urandom};
            push_pair(p);
            drive_half(1'b0, 24, -1, 1'b0, '0);
            check("short_left", cap[22:0], p[63:41]);
            drive_half(1'b1, 24, -1, 1'b0, '0);
            check("short_right", cap[22:0], p[31:9]);
        end

        // Randomised frame lengths and push pattern
        lr = 1'b1;
        for (int i = 0; i < 30; i++) begin
            lr = ~lr;
            if ($urandom_range(0, 9) < 6) offer_q.push_back({$urandom, $urandom});
            drive_half(lr, lens[$urandom_range(0, 4)], -1, 1'b0, '0);
        end
        check("final_uf_count", uf_seen, m_uf_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Transmit-side counterpart of the audio sample path: accepts parallel 32-bit left/right sample pairs from the processing chain through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each pair onto the codec DAC line in I2S format, timed by the codec-supplied bit clock and LR clock.
- Sits between the audio processing blocks and the codec DAC pins, all in the CLOCK_50 domain.

Parameters:
- AUDIO_DATA_WIDTH, 32, bits per channel word; MSB is sent first.
- BIT_COUNTER_INIT, 5'd31, initial bit index loaded at the start of each channel word (AUDIO_DATA_WIDTH-1).
- FIFO_DEPTH, 4, number of left/right pairs buffered; must be a power of two, at least 2.

Ports:
- CLOCK_50  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- left_in  input  AUDIO_DATA_WIDTH  left sample of the offered pair.
- right_in  input  AUDIO_DATA_WIDTH  right sample of the offered pair.
- in_valid  input  1  pair on left_in/right_in is valid.
- in_ready  output  1  FIFO can accept a pair this cycle.
- AUD_BCLK  input  1  codec bit clock, asynchronous to CLOCK_50.
- AUD_DACLRCK  input  1  codec LR clock: low = left, high = right; asynchronous.
- AUD_DACDAT  output  1  serial DAC data.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- underflow  output  1  one-cycle pulse when a left slot starts with the FIFO empty.

Behaviour:
- Reset values: AUD_DACDAT=0, in_ready=1, fifo_level=0, underflow=0; FIFO emptied; shift register 0; bit counter idle; `started`=0. Reset asserted mid-word aborts the word immediately.
- Synchronisation: AUD_BCLK and AUD_DACLRCK each pass through 2 flops, then a third flop for edge detection. The codec BCLK period must be at least 8 CLOCK_50 cycles.
- Edge strobes: bclk_fall, lrck_fall, lrck_rise, each one CLOCK_50 cycle wide.
- Push: a push occurs when in_valid && in_ready; the {left_in,right_in} pair is written at the FIFO tail.
  - in_ready = (fifo_level < FIFO_DEPTH), driven from registered state only.
- Pop: a pop occurs on lrck_fall when fifo_level > 0; the head pair is moved into hold_l/hold_r.
- Push and pop in the same cycle: fifo_level is unchanged and both take effect. At full, in_ready=0, so no push is accepted even if a pop occurs that cycle.
- Underrun: on lrck_fall with the FIFO empty, hold_l and hold_r are set to 0 and underflow pulses for 1 cycle.
- Startup: before the first lrck_fall after reset, `started`=0 and the shifter transmits zeros. lrck_rise is ignored until `started`=1, so a partial first frame is never sent.
- Word load:
  - On lrck_fall, the shift register loads the popped value (or 0 on underrun) and the counter loads BIT_COUNTER_INIT.
  - On lrck_rise (when started), the shift register loads hold_r and the counter loads BIT_COUNTER_INIT.
- I2S one-bit delay: a bclk_fall in the same cycle as, or before, the first bclk_fall following the LR edge does not shift. AUD_DACDAT keeps its previous value (previous word's LSB, or 0) for that delay slot.
- Shifting: on each subsequent bclk_fall while the counter is active, AUD_DACDAT is set to the current bit, starting from the MSB. The counter decrements, and after bit 0 it goes idle.
- Output latency: AUD_DACDAT changes 3 CLOCK_50 cycles after the raw AUD_BCLK falling edge. The codec samples on the rising edge.
- Long frames: if more than 33 BCLKs occur per LR half, AUD_DACDAT is 0 after the LSB.
- Short frames: if an LR edge arrives before bit 0, the current word is truncated and the new word loads; no error is flagged.
- Width rule: all data is passed bit-exact, with no sign extension or clamping.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DATA_WIDTH and BIT_COUNTER_INIT;
  - audio_pair_t, a struct of left and right each AUDIO_DATA_WIDTH wide.
- One sub-module: audio_pair_fifo, a synchronous FIFO (parameter FIFO_DEPTH) with push/pop, full/empty and level outputs.
- Synchronisers, edge detection, hold registers and the shifter remain in audio_dac_serializer.

Test Plan:
- Push L=0x80000001, R=0x7FFFFFFE; drive BCLK=CLOCK_50/16 with 64 BCLK per frame -> after the first lrck_fall plus a 1-BCLK delay, the DAC emits 1,0…0,1 (32 bits), then after lrck_rise it emits 0,1…1,0; underflow stays 0.
- No pushes after reset, LRCK running -> AUD_DACDAT is constantly 0; underflow pulses once per lrck_fall; fifo_level=0.
- Hold in_valid=1 with LRCK stopped -> exactly 4 pairs are accepted, then in_ready=0 and fifo_level=4. Start LRCK -> at the first lrck_fall, in_ready rises and the level drops to 3.
- Push and pop coincide at level 2 -> level stays 2, and pair order is preserved in the serial output.
- Assert reset mid-left-word (after 10 bits sent) -> AUD_DACDAT=0 immediately and the FIFO is empty. After release, nothing is sent until the next lrck_fall.
- Drive 48 BCLK per frame (24 per half) -> each word is truncated to its 23 MSBs; the next word starts correctly with no lockup.
